// File: rtl/wb_loader_pkg.sv
// Shared constants and state encoding for the byte-stream to Wishbone loader.
package wb_loader_pkg;

  localparam logic [7:0] CmdWrite    = 8'h57;
  localparam logic [7:0] CmdRead     = 8'h52;
  localparam logic [7:0] CmdHold     = 8'h48;
  localparam logic [7:0] CmdGo       = 8'h47;

  localparam logic [7:0] RespOk      = 8'h4B;
  localparam logic [7:0] RespTimeout = 8'h54;
  localparam logic [7:0] RespBad     = 8'h3F;

  localparam logic [2:0] ReplyShort  = 3'd1;
  localparam logic [2:0] ReplyRead   = 3'd5;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  function automatic logic is_bus_cmd(input logic [7:0] b);
    return (b == CmdWrite) || (b == CmdRead);
  endfunction

endpackage

// File: rtl/wb_loader_tx.sv
// Reply serializer: holds up to five bytes and presents them one at a time on a
// valid/ready interface, byte 0 first.
module wb_loader_tx
  import wb_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [2:0]  load_len,
  input  logic [39:0] load_bytes,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [39:0] buf_q;
  logic [2:0]  len_q;
  logic [2:0]  idx_q;
  logic        last;

  assign last    = (idx_q == 3'(len_q - 3'd1));
  assign done    = tx_valid & tx_ready & last;
  assign tx_data = buf_q[{idx_q, 3'b000} +: 8];

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      buf_q    <= load_bytes;
      len_q    <= load_len;
      idx_q    <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (last) begin
        tx_valid <= 1'b0;
        idx_q    <= '0;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/wb_loader.sv
// Host command parser that issues single Wishbone cycles and returns status/read bytes;
// also owns the CPU hold line used while images are loaded.
module wb_loader
  import wb_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          HOLD_ON_RESET  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        cpu_hold,
  output logic        busy
);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        is_write_q;
  logic [31:0] addr_sh_q;
  logic [31:0] data_sh_q;
  logic [7:0]  tmo_q;
  logic        rx_fire;
  logic        tmo_last;
  logic        tx_load;
  logic [2:0]  tx_len;
  logic [39:0] tx_bytes;
  logic        tx_done;

  assign rx_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StData);
  assign busy     = (state_q != StIdle);
  assign rx_fire  = rx_valid & rx_ready;
  assign tmo_last = (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  // Reply is loaded on the same edge that finishes the command, so the first
  // byte appears one cycle later.
  always_comb begin
    tx_load  = 1'b0;
    tx_len   = ReplyShort;
    tx_bytes = {32'h0, RespOk};
    unique case (state_q)
      StIdle: begin
        if (rx_fire && !is_bus_cmd(rx_data)) begin
          tx_load = 1'b1;
          if (rx_data != CmdHold && rx_data != CmdGo) tx_bytes = {32'h0, RespBad};
        end
      end
      StBus: begin
        if (wb_ack_i) begin
          tx_load  = 1'b1;
          tx_len   = is_write_q ? ReplyShort : ReplyRead;
          tx_bytes = {wb_data_i, RespOk};
        end else if (tmo_last) begin
          tx_load  = 1'b1;
          tx_bytes = {32'h0, RespTimeout};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tmo_q       <= '0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_strobe_o <= 1'b0;
      wb_we_o     <= 1'b0;
      cpu_hold    <= HOLD_ON_RESET;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_fire) begin
            cnt_q      <= '0;
            is_write_q <= (rx_data == CmdWrite);
            state_q    <= is_bus_cmd(rx_data) ? StAddr : StResp;
            if (rx_data == CmdHold) cpu_hold <= 1'b1;
            if (rx_data == CmdGo)   cpu_hold <= 1'b0;
          end
        end
        StAddr: begin
          if (rx_fire) begin
            addr_sh_q <= {rx_data, addr_sh_q[31:8]};
            cnt_q     <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= StData;
              end else begin
                wb_addr_o   <= {rx_data, addr_sh_q[31:8]};
                wb_cyc_o    <= 1'b1;
                wb_strobe_o <= 1'b1;
                wb_we_o     <= 1'b0;
                tmo_q       <= '0;
                state_q     <= StBus;
              end
            end
          end
        end
        StData: begin
          if (rx_fire) begin
            data_sh_q <= {rx_data, data_sh_q[31:8]};
            cnt_q     <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              wb_addr_o   <= addr_sh_q;
              wb_data_o   <= {rx_data, data_sh_q[31:8]};
              wb_cyc_o    <= 1'b1;
              wb_strobe_o <= 1'b1;
              wb_we_o     <= 1'b1;
              tmo_q       <= '0;
              state_q     <= StBus;
            end
          end
        end
        StBus: begin
          if (wb_ack_i || tmo_last) begin
            wb_cyc_o    <= 1'b0;
            wb_strobe_o <= 1'b0;
            wb_we_o     <= 1'b0;
            state_q     <= StResp;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        StResp: begin
          if (tx_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  wb_loader_tx u_tx (
    .clock      (clock),
    .reset      (reset),
    .load       (tx_load),
    .load_len   (tx_len),
    .load_bytes (tx_bytes),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .done       (tx_done)
  );

endmodule

// File: tb/tb_wb_loader.sv
// Self-checking bench for wb_loader: directed scenarios followed by random commands
// checked against a command-level model (memory map, hold flag, expected reply bytes).
module tb_wb_loader;

  localparam int unsigned TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic        wb_we_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        cpu_hold;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        hold_m;
  logic [31:0] mem [logic [31:0]];
  logic [7:0]  exp_q [$];

  wb_loader #(.TIMEOUT_CYCLES(TMO), .HOLD_ON_RESET(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_we_o     (wb_we_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i),
    .cpu_hold    (cpu_hold),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one byte, optionally after idle cycles with rx_valid low and junk data.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_data = 8'($urandom);
      step();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) chk("rx_ready_wait", {39'h0, rx_ready}, 40'h1);
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
  endtask

  // Drain exp_q from the tx port; bp<0 picks random backpressure per byte.
  task automatic expect_reply(input int bp);
    int n;
    int hold;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (!tx_valid && n < 50) begin
        step();
        n++;
      end
      chk("tx_valid_wait", {39'h0, tx_valid}, 40'h1);
      hold = (bp >= 0) ? bp : (($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 1)) : 0);
      tx_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        chk("bp_tx_data", {32'h0, tx_data}, {32'h0, e});
        chk("bp_tx_valid", {39'h0, tx_valid}, 40'h1);
        chk("bp_rx_ready", {39'h0, rx_ready}, 40'h0);
      end
      tx_ready = 1'b1;
      chk("tx_data", {32'h0, tx_data}, {32'h0, e});
      step();
    end
    tx_ready = 1'b0;
    chk("tx_valid_end", {39'h0, tx_valid}, 40'h0);
    chk("busy_end", {39'h0, busy}, 40'h0);
  endtask

  // Act as the Wishbone slave: ack after `delay` wait cycles with read data rd.
  task automatic service_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input int delay, input logic [31:0] rd);
    chk("cyc_start", {39'h0, wb_cyc_o}, 40'h1);
    for (int i = 0; i < delay; i++) begin
      chk("cyc_wait", {38'h0, wb_cyc_o, wb_strobe_o}, 40'h3);
      step();
    end
    wb_ack_i  = 1'b1;
    wb_data_i = rd;
    chk("cyc_ack", {38'h0, wb_cyc_o, wb_strobe_o}, 40'h3);
    chk("wb_we", {39'h0, wb_we_o}, {39'h0, we});
    chk("wb_addr", {8'h0, wb_addr_o}, {8'h0, addr});
    if (we) chk("wb_data", {8'h0, wb_data_o}, {8'h0, wd});
    step();
    wb_ack_i  = 1'b0;
    wb_data_i = $urandom;
    chk("cyc_after_ack", {38'h0, wb_cyc_o, wb_strobe_o}, 40'h0);
    chk("first_byte_latency", {39'h0, tx_valid}, 40'h1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int delay,
                          input int gap);
    send_byte(8'h57, gap);
    send_word(a, gap);
    send_word(d, gap);
    service_bus(1'b1, a, d, delay, $urandom);
    mem[a] = d;
    exp_q.push_back(8'h4B);
    expect_reply(-1);
  endtask

  task automatic do_read(input logic [31:0] a, input int delay, input int gap, input int bp);
    logic [31:0] v;
    if (!mem.exists(a)) mem[a] = $urandom;
    v = mem[a];
    send_byte(8'h52, gap);
    send_word(a, gap);
    service_bus(1'b0, a, 32'h0, delay, v);
    exp_q.push_back(8'h4B);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    expect_reply(bp);
  endtask

  task automatic do_ctrl(input logic [7:0] b);
    send_byte(b, 2);
    if (b == 8'h48) hold_m = 1'b1;
    else if (b == 8'h47) hold_m = 1'b0;
    chk("cpu_hold", {39'h0, cpu_hold}, {39'h0, hold_m});
    chk("ctrl_latency", {39'h0, tx_valid}, 40'h1);
    exp_q.push_back((b == 8'h48 || b == 8'h47) ? 8'h4B : 8'h3F);
    expect_reply(-1);
  endtask

  initial begin
    int n;
    int kind;
    logic [7:0] b;
    hold_m = 1'b1;
    step();
    step();
    chk("rst_rx_ready", {39'h0, rx_ready}, 40'h1);
    chk("rst_tx_valid", {39'h0, tx_valid}, 40'h0);
    chk("rst_wb_ctl", {37'h0, wb_cyc_o, wb_strobe_o, wb_we_o}, 40'h0);
    chk("rst_wb_addr", {8'h0, wb_addr_o}, 40'h0);
    chk("rst_wb_data", {8'h0, wb_data_o}, 40'h0);
    chk("rst_tx_data", {32'h0, tx_data}, 40'h0);
    chk("rst_busy", {39'h0, busy}, 40'h0);
    chk("rst_cpu_hold", {39'h0, cpu_hold}, 40'h1);
    reset = 1'b0;
    step();

    do_write(32'h0001_0000, 32'hDEAD_BEEF, 3, 0);
    mem[32'h4] = 32'h0000_000A;
    do_read(32'h4, 2, 0, 10);

    // Timeout: no ack ever
    send_byte(8'h52, 0);
    send_word(32'h0003_0000, 0);
    n = 0;
    while (wb_cyc_o && n < int'(TMO) + 10) begin
      step();
      n++;
    end
    chk("timeout_cycles", 40'(n), 40'(TMO));
    exp_q.push_back(8'h54);
    expect_reply(-1);

    // Ack on the final timeout cycle still counts as success
    do_read(32'h0001_0010, int'(TMO) - 1, 0, 0);
    do_read(32'h0001_0000, 0, 1, 0);

    do_ctrl(8'h47);
    do_ctrl(8'h48);
    do_ctrl(8'h00);
    do_write(32'h0001_0020, 32'h1234_5678, 1, 3);
    do_read(32'h0001_0020, 4, 3, -1);

    // Reset while the bus cycle is outstanding
    send_byte(8'h57, 0);
    send_word(32'h0001_0030, 0);
    send_word(32'hCAFE_F00D, 0);
    step();
    step();
    chk("pre_reset_cyc", {39'h0, wb_cyc_o}, 40'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    hold_m = 1'b1;
    chk("rbus_ctl", {38'h0, wb_cyc_o, wb_strobe_o}, 40'h0);
    chk("rbus_tx_valid", {39'h0, tx_valid}, 40'h0);
    chk("rbus_busy", {39'h0, busy}, 40'h0);
    chk("rbus_hold", {39'h0, cpu_hold}, 40'h1);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("late_ack_busy", {39'h0, busy}, 40'h0);
    chk("late_ack_tx", {39'h0, tx_valid}, 40'h0);
    do_write(32'h0001_0030, 32'h0BAD_CAFE, 2, 0);

    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(4, 0));
      case (kind)
        0, 1: do_write({14'h0, 2'($urandom_range(1, 0)), 8'h0, 8'($urandom)}, $urandom,
                       int'($urandom_range(6, 0)), 2);
        2: do_read({14'h0, 2'($urandom_range(1, 0)), 8'h0, 8'($urandom_range(15, 0))},
                   int'($urandom_range(6, 0)), 2, -1);
        3: do_ctrl(($urandom_range(1, 0) == 1) ? 8'h48 : 8'h47);
        default: begin
          b = 8'($urandom);
          if (b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47) b = 8'hFF;
          do_ctrl(b);
        end
      endcase
      chk("rand_hold", {39'h0, cpu_hold}, {39'h0, hold_m});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
